ddma_noc_rx: RTL and testbench
==============================

DDMA_NOC_RX -- requirements
Module: ddma_noc_rx

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter MEMORY_BUS_WIDTH, default 32, memory write data width.
REQ-003 SHALL have parameter MEMORY_SIZE, default 'h8000, memory size in bytes.
REQ-004 SHALL have parameter MEMORY_BASE, default 0, lowest writable byte address.
REQ-005 SHALL have parameter ADDRESS, default 0, this PE's router address in header bits [FLIT_WIDTH/2-1:0].
REQ-006 SHALL have parameter BUFFER_DEPTH, default 4, input FIFO depth in flits, power of two.
REQ-007 clock  input  1  single clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 rx  input  1  flit valid from router LOCAL output.
REQ-010 data_i  input  FLIT_WIDTH  flit from router LOCAL output.
REQ-011 credit_o  output  1  space available; a flit transfers when rx && credit_o at a rising edge.
REQ-012 mem_wr_o  output  1  memory write strobe, one word per cycle.
REQ-013 mem_addr_o  output  32  byte address of the write.
REQ-014 mem_data_o  output  MEMORY_BUS_WIDTH  write data.
REQ-015 mem_busy_i  input  1  memory stall; while high, no write is issued and the FIFO is not popped.
REQ-016 pkt_done_o  output  1  one-cycle pulse when a valid packet's last word is written.
REQ-017 pkt_err_o  output  1  one-cycle pulse when a packet is discarded.
REQ-018 rx_count_o  output  16  count of completed packets.

Function
REQ-019 Packet format SHALL be: header flit, size flit N, N flits; the first of the N is the memory byte address A; the remaining N-1 are data words.
REQ-020 Accepted flits SHALL enter the FIFO; credit_o SHALL equal FIFO-not-full, registered.
REQ-021 On a simultaneous push and pop while full, the push SHALL be accepted only if credit_o was high in that cycle.
REQ-022 FSM states SHALL be S_HEADER, S_SIZE, S_ADDR, S_DATA, S_DROP; each state pops one flit per cycle when the FIFO is non-empty.
REQ-023 S_HEADER: if header[FLIT_WIDTH/2-1:0] == ADDRESS, go to S_SIZE; otherwise latch a drop flag and go to S_SIZE.
REQ-024 S_SIZE: N==0 SHALL pulse pkt_err_o and return to S_HEADER; N==1 SHALL go to S_ADDR and complete with no writes.
REQ-025 S_ADDR: if the drop flag is set, A<MEMORY_BASE, A is not word-aligned, or A+(N-1)*4 > MEMORY_BASE+MEMORY_SIZE, go to S_DROP; else go to S_DATA.
REQ-026 S_DATA: each pop SHALL drive mem_wr_o=1 in the next cycle with mem_addr_o=current address; the address SHALL then advance by MEMORY_BUS_WIDTH/8.
REQ-027 Write latency SHALL be 1 cycle from FIFO pop; throughput SHALL be 1 word/cycle when not stalled.
REQ-028 When mem_busy_i is high, mem_wr_o SHALL be 0 and the FSM SHALL hold without losing data.
REQ-029 pkt_done_o SHALL pulse in the same cycle as the last mem_wr_o; the FSM returns to S_HEADER.
REQ-030 S_DROP SHALL consume the remaining N-1 flits with no writes, pulse pkt_err_o on the last one, then return to S_HEADER.
REQ-031 The remaining-flit counter SHALL be FLIT_WIDTH bits wide; address arithmetic SHALL be 32 bits and SHALL NOT wrap, because the range check rejects overflow.

Reset
REQ-032 On reset low: FSM=S_HEADER, FIFO empty, credit_o=0, mem_wr_o=0, mem_addr_o=0, mem_data_o=0, pkt_done_o=0, pkt_err_o=0, rx_count_o=0.
REQ-033 credit_o SHALL rise on the first clock after reset deasserts.
REQ-034 Reset mid-packet SHALL discard the packet, with no further writes and no pulses.

Configuration
REQ-035 Macro DDMA_NOC_RX_STATS_EN defined: rx_count_o SHALL increment on each pkt_done_o and saturate at 16'hFFFF.
REQ-036 Macro DDMA_NOC_RX_STATS_EN undefined: rx_count_o SHALL be constant 0 and no counter SHALL be synthesised.

Structure
REQ-037 Package ddma_pkg SHALL hold the FSM state enum, the e_port enum and the header/size field constants.
REQ-038 The FIFO SHALL be the sub-module ddma_rx_fifo (parameters FLIT_WIDTH, BUFFER_DEPTH; push/pop/full/empty).

Verification
REQ-039 ADDRESS=0; packet {0x0, 3, 0x100, 0xAAAA, 0xBBBB}: writes 0x100<-0xAAAA then 0x104<-0xBBBB; pkt_done_o pulses once.
REQ-040 Header 0x0101 with ADDRESS=0, N=3: no mem_wr_o; pkt_err_o pulses on the 5th flit; the next valid packet is written correctly.
REQ-041 A=0x7FFC, N=3 (overruns 0x8000): no writes, pkt_err_o pulses; N=0: pkt_err_o pulses after the size flit.
REQ-042 mem_busy_i high for 10 cycles mid-payload with rx held high: credit_o falls after BUFFER_DEPTH flits; all words are written in order with no loss.
REQ-043 Reset low during the 3rd data flit: outputs take reset values immediately; after release, a fresh packet is written correctly.
REQ-044 With DDMA_NOC_RX_STATS_EN, 3 valid and 1 bad packet: rx_count_o=3; without the macro, rx_count_o=0.

Source files
------------

// File: rtl/ddma_pkg.sv
// ddma_pkg -- shared FSM state codes, router port enum and header field positions (rev 1.0)
`default_nettype none

package ddma_pkg;

    typedef logic [2:0] ddma_state_t;

    localparam ddma_state_t S_HEADER = 3'd0;
    localparam ddma_state_t S_SIZE   = 3'd1;
    localparam ddma_state_t S_ADDR   = 3'd2;
    localparam ddma_state_t S_DATA   = 3'd3;
    localparam ddma_state_t S_DROP   = 3'd4;

    typedef enum logic [2:0] {
        PORT_EAST  = 3'd0,
        PORT_WEST  = 3'd1,
        PORT_NORTH = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_LOCAL = 3'd4
    } e_port;

    // Destination router address occupies the low half of the header flit
    localparam int HDR_DEST_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/ddma_rx_fifo.sv
// ddma_rx_fifo -- power-of-two flit FIFO with push/pop/full/empty and occupancy (rev 1.0)
`default_nettype none

module ddma_rx_fifo #(
    parameter int FLIT_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [FLIT_WIDTH-1:0]         wdata,
    input  logic                          pop,
    output logic [FLIT_WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(BUFFER_DEPTH):0] count
);

    localparam int            AW    = $clog2(BUFFER_DEPTH);
    localparam logic [AW:0]   PTR_1 = (AW+1)'(1);

    logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    // Extra pointer bit distinguishes full from empty when the indices match
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_1;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddma_noc_rx.sv
// ddma_noc_rx -- NoC receive DMA: buffers LOCAL-port flits and writes packet payloads to memory (rev 1.0)
// Optional packet counter on rx_count_o enabled by macro DDMA_NOC_RX_STATS_EN.
`default_nettype none

module ddma_noc_rx
    import ddma_pkg::*;
#(
    parameter int FLIT_WIDTH       = 32,
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int MEMORY_SIZE      = 'h8000,
    parameter int MEMORY_BASE      = 0,
    parameter int ADDRESS          = 0,
    parameter int BUFFER_DEPTH     = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx,
    input  logic [FLIT_WIDTH-1:0]       data_i,
    output logic                        credit_o,
    output logic                        mem_wr_o,
    output logic [31:0]                 mem_addr_o,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_o,
    input  logic                        mem_busy_i,
    output logic                        pkt_done_o,
    output logic                        pkt_err_o,
    output logic [15:0]                 rx_count_o
);

    localparam int                    CW         = $clog2(BUFFER_DEPTH) + 1;
    localparam int                    HALF       = FLIT_WIDTH / 2;
    localparam int                    BUS_BYTES  = MEMORY_BUS_WIDTH / 8;
    localparam logic [HALF-1:0]       MY_ADDR    = HALF'(ADDRESS);
    localparam logic [CW-1:0]         DEPTH_C    = CW'(BUFFER_DEPTH);
    localparam logic [CW-1:0]         CNT_1      = CW'(1);
    localparam logic [FLIT_WIDTH-1:0] REM_1      = FLIT_WIDTH'(1);
    localparam logic [31:0]           BASE_C     = 32'(MEMORY_BASE);
    localparam logic [31:0]           STEP_C     = 32'(BUS_BYTES);
    localparam logic [31:0]           ALIGN_MASK = 32'(BUS_BYTES - 1);
    localparam logic [63:0]           STEP_64    = 64'(BUS_BYTES);
    localparam logic [63:0]           LIMIT_C    = 64'(MEMORY_BASE) + 64'(MEMORY_SIZE);

    ddma_state_t                 state;
    logic                        drop;
    logic [FLIT_WIDTH-1:0]       remain;
    logic [31:0]                 cur_addr;
    logic                        wr_pend;
    logic                        done_pend;

    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CW-1:0]               fifo_count;
    logic [CW-1:0]               count_next;
    logic [FLIT_WIDTH-1:0]       flit;
    logic [HALF-1:0]             dest;
    logic [31:0]                 addr_flit;
    logic [MEMORY_BUS_WIDTH-1:0] data_flit;
    logic [63:0]                 end_addr;
    logic                        below_base;
    logic                        bad;

    ddma_rx_fifo #(
        .FLIT_WIDTH   (FLIT_WIDTH),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (data_i),
        .pop   (pop),
        .rdata (flit),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign push = rx && credit_o && !fifo_full;
    assign pop  = !fifo_empty && !mem_busy_i;

    // Credit is registered from the next occupancy so it never over-promises space
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CNT_1;
        end else if (pop && !push) begin
            count_next = fifo_count - CNT_1;
        end
    end

    assign dest      = flit[HDR_DEST_LSB +: HALF];
    assign addr_flit = 32'(flit);
    assign data_flit = MEMORY_BUS_WIDTH'(flit);
    assign end_addr  = {32'd0, addr_flit} + (64'(remain) * STEP_64);

    if (MEMORY_BASE == 0) begin : g_base_zero
        assign below_base = 1'b0;
    end else begin : g_base_nonzero
        assign below_base = (addr_flit < BASE_C);
    end

    assign bad = drop || below_base || ((addr_flit & ALIGN_MASK) != 32'd0) || (end_addr > LIMIT_C);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_HEADER;
            drop       <= 1'b0;
            remain     <= '0;
            cur_addr   <= '0;
            credit_o   <= 1'b0;
            wr_pend    <= 1'b0;
            done_pend  <= 1'b0;
            pkt_err_o  <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            credit_o  <= (count_next != DEPTH_C);
            pkt_err_o <= 1'b0;
            // A pending write is held across a stall and retired once busy drops
            if (!mem_busy_i) begin
                wr_pend   <= 1'b0;
                done_pend <= 1'b0;
            end
            if (pop) begin
                case (state)
                    S_HEADER: begin
                        drop  <= (dest != MY_ADDR);
                        state <= S_SIZE;
                    end
                    S_SIZE: begin
                        if (flit == '0) begin
                            pkt_err_o <= 1'b1;
                            state     <= S_HEADER;
                        end else begin
                            remain <= flit - REM_1;
                            state  <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        cur_addr <= addr_flit;
                        if (remain == '0) begin
                            pkt_err_o <= bad;
                            state     <= S_HEADER;
                        end else if (bad) begin
                            state <= S_DROP;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        wr_pend    <= 1'b1;
                        mem_addr_o <= cur_addr;
                        mem_data_o <= data_flit;
                        cur_addr   <= cur_addr + STEP_C;
                        remain     <= remain - REM_1;
                        if (remain == REM_1) begin
                            done_pend <= 1'b1;
                            state     <= S_HEADER;
                        end
                    end
                    S_DROP: begin
                        remain <= remain - REM_1;
                        if (remain == REM_1) begin
                            pkt_err_o <= 1'b1;
                            state     <= S_HEADER;
                        end
                    end
                    default: state <= S_HEADER;
                endcase
            end
        end
    end

    assign mem_wr_o   = wr_pend && !mem_busy_i;
    assign pkt_done_o = done_pend && !mem_busy_i;

`ifdef DDMA_NOC_RX_STATS_EN
    logic [15:0] pkt_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
        end else if (pkt_done_o && (pkt_count != 16'hFFFF)) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

    assign rx_count_o = pkt_count;
`else
    assign rx_count_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddma_noc_rx.sv
// tb_ddma_noc_rx -- directed and randomized checks of ddma_noc_rx against a packet-level reference model
`default_nettype none

module tb_ddma_noc_rx;

    localparam int ADDRESS  = 0;
    localparam int MEM_BASE = 0;
    localparam int MEM_SIZE = 'h8000;
    localparam int DEPTH    = 4;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic        rx         = 1'b0;
    logic [31:0] data_i     = '0;
    logic        mem_busy_i = 1'b0;
    logic        credit_o;
    logic        mem_wr_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        pkt_done_o;
    logic        pkt_err_o;
    logic [15:0] rx_count_o;

    always #5 clock = ~clock;

    ddma_noc_rx #(
        .FLIT_WIDTH       (32),
        .MEMORY_BUS_WIDTH (32),
        .MEMORY_SIZE      (MEM_SIZE),
        .MEMORY_BASE      (MEM_BASE),
        .ADDRESS          (ADDRESS),
        .BUFFER_DEPTH     (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data_i     (data_i),
        .credit_o   (credit_o),
        .mem_wr_o   (mem_wr_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_busy_i (mem_busy_i),
        .pkt_done_o (pkt_done_o),
        .pkt_err_o  (pkt_err_o),
        .rx_count_o (rx_count_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] pkt[$];
    int done_cnt  = 0;
    int err_cnt   = 0;
    int busy_viol = 0;
    int done_viol = 0;
    int exp_done  = 0;
    int exp_err   = 0;
    int done_base = 0;
    int err_base  = 0;
    int acc_cnt   = 0;
    bit stop_busy = 0;

    // Observed memory traffic and pulses, sampled on the falling edge
    always @(negedge clock) begin
        if (reset) begin
            if (mem_wr_o) begin
                obs_addr.push_back(mem_addr_o);
                obs_data.push_back(mem_data_o);
            end
            if (pkt_done_o) done_cnt++;
            if (pkt_err_o) err_cnt++;
            if (mem_wr_o && mem_busy_i) busy_viol++;
            if (pkt_done_o && !mem_wr_o) done_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_rx_count();
`ifdef DDMA_NOC_RX_STATS_EN
        return (exp_done > 65535) ? 16'hFFFF : 16'(exp_done);
`else
        return 16'd0;
`endif
    endfunction

    // Packet-level reference: which words land where, and which packets are discarded
    task automatic model_pkt();
        logic [31:0] h;
        logic [31:0] n;
        logic [31:0] a;
        logic [63:0] last;
        bit          ok;
        h = pkt[0];
        n = pkt[1];
        if (n == 32'd0) begin
            exp_err++;
            return;
        end
        a    = pkt[2];
        last = 64'(a) + 64'(n - 32'd1) * 64'd4;
        ok   = (h[15:0] == 16'(ADDRESS)) && (64'(a) + 64'd1 > 64'(MEM_BASE)) &&
               (a % 32'd4 == 32'd0) && (last <= 64'(MEM_BASE) + 64'(MEM_SIZE));
        if (ok) begin
            for (int i = 0; i < int'(n) - 1; i++) begin
                exp_addr.push_back(a + 32'(4 * i));
                exp_data.push_back(pkt[3 + i]);
            end
            exp_done++;
        end else begin
            exp_err++;
        end
    endtask

    task automatic make_pkt(input logic [31:0] hdr, input logic [31:0] n, input logic [31:0] a);
        pkt.delete();
        pkt.push_back(hdr);
        pkt.push_back(n);
        if (n != 32'd0) begin
            pkt.push_back(a);
            for (int i = 1; i < int'(n); i++) pkt.push_back($urandom);
        end
    endtask

    task automatic send_flit(input logic [31:0] v);
        bit acc;
        acc    = 1'b0;
        rx     = 1'b1;
        data_i = v;
        for (int c = 0; c < 500 && !acc; c++) begin
            @(negedge clock);
            acc = credit_o;
            @(posedge clock);
            #1;
        end
        check("flit_accepted", 64'(acc), 64'd1);
        rx = 1'b0;
    endtask

    task automatic send_pkt();
        model_pkt();
        foreach (pkt[i]) send_flit(pkt[i]);
    endtask

    task automatic drain();
        repeat (20) @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_nwrites"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        while (exp_addr.size() > 0 && obs_addr.size() > 0) begin
            check({tag, "_addr"}, 64'(obs_addr.pop_front()), 64'(exp_addr.pop_front()));
            check({tag, "_data"}, 64'(obs_data.pop_front()), 64'(exp_data.pop_front()));
        end
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
        check({tag, "_done"}, 64'(done_cnt - done_base), 64'(exp_done));
        check({tag, "_err"}, 64'(err_cnt - err_base), 64'(exp_err));
        check({tag, "_wr_while_busy"}, 64'(busy_viol), 64'd0);
        check({tag, "_done_without_wr"}, 64'(done_viol), 64'd0);
        check({tag, "_rx_count"}, 64'(rx_count_o), 64'(exp_rx_count()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] hdr;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_credit", 64'(credit_o), 64'd0);
        check("rst_mem_wr", 64'(mem_wr_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst_mem_data", 64'(mem_data_o), 64'd0);
        check("rst_done", 64'(pkt_done_o), 64'd0);
        check("rst_err", 64'(pkt_err_o), 64'd0);
        check("rst_rx_count", 64'(rx_count_o), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("credit_before_first_clk", 64'(credit_o), 64'd0);
        @(negedge clock);
        check("credit_after_first_clk", 64'(credit_o), 64'd1);
        @(posedge clock); #1;

        // Basic valid packet
        make_pkt(32'h0, 32'd3, 32'h100);
        pkt[3] = 32'hAAAA;
        pkt[4] = 32'hBBBB;
        send_pkt();
        drain();
        check_all("basic");

        // Foreign destination dropped, then a valid packet
        make_pkt(32'h0101, 32'd3, 32'h200);
        send_pkt();
        make_pkt(32'h0, 32'd4, 32'h240);
        send_pkt();
        drain();
        check_all("foreign_hdr");

        // Overrun of memory top, and zero size
        make_pkt(32'h0, 32'd3, 32'h7FFC);
        send_pkt();
        make_pkt(32'h0, 32'd0, 32'h0);
        send_pkt();
        make_pkt(32'h0, 32'd3, 32'h7FF8);
        send_pkt();
        drain();
        check_all("range_and_zero");

        // Memory stall with rx held high: credit drops after DEPTH flits
        make_pkt(32'h0, 32'd8, 32'h400);
        mem_busy_i = 1'b1;
        acc_cnt    = 0;
        fork
            send_pkt();
            begin
                repeat (10) begin
                    @(negedge clock);
                    if (rx && credit_o) acc_cnt++;
                end
                check("busy_accepted", 64'(acc_cnt), 64'(DEPTH));
                check("busy_credit_low", 64'(credit_o), 64'd0);
                check("busy_no_writes", 64'(obs_addr.size()), 64'd0);
                @(posedge clock); #1;
                mem_busy_i = 1'b0;
            end
        join
        drain();
        check_all("stall");

        // Randomized packets with random stalls
        stop_busy = 1'b0;
        fork
            begin
                for (int p = 0; p < 10; p++) begin
                    r   = $urandom;
                    hdr = ($urandom_range(0, 4) == 0) ? {r[31:16], 16'h0003} : {r[31:16], 16'h0000};
                    a   = 32'($urandom_range(0, 32'h1F00)) & ~32'd3;
                    case ($urandom_range(0, 5))
                        0:       a = a | 32'd2;
                        1:       a = 32'h7FF0;
                        default: ;
                    endcase
                    make_pkt(hdr, 32'($urandom_range(2, 6)), a);
                    send_pkt();
                end
                stop_busy = 1'b1;
            end
            begin
                while (!stop_busy) begin
                    @(posedge clock); #1;
                    mem_busy_i = ($urandom_range(0, 3) == 0);
                end
                mem_busy_i = 1'b0;
            end
        join
        drain();
        check_all("random");

        // Reset in the middle of a payload
        make_pkt(32'h0, 32'd5, 32'h300);
        for (int i = 0; i < 5; i++) send_flit(pkt[i]);
        rx     = 1'b1;
        data_i = pkt[5];
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        check("midrst_credit", 64'(credit_o), 64'd0);
        check("midrst_mem_wr", 64'(mem_wr_o), 64'd0);
        check("midrst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("midrst_mem_data", 64'(mem_data_o), 64'd0);
        check("midrst_done", 64'(pkt_done_o), 64'd0);
        check("midrst_err", 64'(pkt_err_o), 64'd0);
        check("midrst_rx_count", 64'(rx_count_o), 64'd0);
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
        exp_done  = 0;
        exp_err   = 0;
        done_base = done_cnt;
        err_base  = err_cnt;
        rx        = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check_all("after_reset_idle");

        // Fresh traffic after reset: three valid, one bad
        make_pkt(32'h0, 32'd3, 32'h500);
        send_pkt();
        make_pkt(32'h0, 32'd2, 32'h600);
        send_pkt();
        make_pkt(32'h0, 32'd4, 32'h501);
        send_pkt();
        make_pkt(32'h0, 32'd5, 32'h700);
        send_pkt();
        drain();
        check_all("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
